// File: rtl/keypad_if.sv
// Keypad-side signals of the calculator front end: matrix scan lines plus the
// value/trig/key_down strobe pair consumed by the control unit.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] value;
    logic       trig;
    logic       key_down;

    modport master (
        input  row,
        output col,
        output value,
        output trig,
        output key_down
    );

    modport slave (
        output row,
        input  col,
        input  value,
        input  trig,
        input  key_down
    );
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 active-low keypad scanner with press/release debounce and key encoding.
// Optional auto-repeat while a key is held is enabled by KEYPAD_AUTOREPEAT_EN.
module keypad_encoder #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TRIG_LEN        = 4,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic     clk,
    input  logic     clr_all,
    keypad_if.master kp
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STB_W  = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_FULL  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(TRIG_LEN - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_FULL = REP_W'(REPEAT_CYCLES);
`endif

    typedef enum logic [2:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_STROBE,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t              state, state_n;
    logic [1:0]          col_idx, col_idx_n;
    logic [SCAN_W-1:0]   scan_cnt, scan_cnt_n;
    logic [DEB_W-1:0]    cnt, cnt_n;
    logic [STB_W-1:0]    stb_cnt, stb_cnt_n;
    logic [3:0]          row_lat, row_lat_n;
    logic [3:0]          value_q, value_n;
    logic                key_down_q, key_down_n;
    logic                trig_q, trig_n;
    logic [3:0]          row_p0, row_p1;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0]    rep_cnt, rep_cnt_n;
`endif

    function automatic logic exactly_one_low(input logic [3:0] r);
        case (r)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] r);
        case (r)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'd1;
            4'h1: return 4'd2;
            4'h2: return 4'd3;
            4'h3: return 4'b1010;
            4'h4: return 4'd4;
            4'h5: return 4'd5;
            4'h6: return 4'd6;
            4'h7: return 4'b1011;
            4'h8: return 4'd7;
            4'h9: return 4'd8;
            4'hA: return 4'd9;
            4'hB: return 4'b1100;
            4'hC: return 4'b1101;
            4'hD: return 4'd0;
            4'hE: return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DEB_W-1:0] sat_inc_deb(input logic [DEB_W-1:0] v);
        return (v >= DEB_FULL) ? DEB_FULL : v + 1'b1;
    endfunction

`ifdef KEYPAD_AUTOREPEAT_EN
    function automatic logic [REP_W-1:0] sat_inc_rep(input logic [REP_W-1:0] v);
        return (v >= REP_FULL) ? REP_FULL : v + 1'b1;
    endfunction
`endif

    // Stage p0/p1: two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge clr_all) begin
        if (!clr_all) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= kp.row;
            row_p1 <= row_p0;
        end
    end

    always_ff @(posedge clk or negedge clr_all) begin
        if (!clr_all) begin
            state      <= ST_SCAN;
            col_idx    <= 2'd0;
            scan_cnt   <= '0;
            cnt        <= '0;
            stb_cnt    <= '0;
            row_lat    <= 4'hF;
            value_q    <= 4'h0;
            key_down_q <= 1'b0;
            trig_q     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            col_idx    <= col_idx_n;
            scan_cnt   <= scan_cnt_n;
            cnt        <= cnt_n;
            stb_cnt    <= stb_cnt_n;
            row_lat    <= row_lat_n;
            value_q    <= value_n;
            key_down_q <= key_down_n;
            trig_q     <= trig_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt    <= rep_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        col_idx_n  = col_idx;
        scan_cnt_n = scan_cnt;
        cnt_n      = cnt;
        stb_cnt_n  = stb_cnt;
        row_lat_n  = row_lat;
        value_n    = value_q;
        key_down_n = key_down_q;
        // trig lags the STROBE state by one clock so value always leads it
        trig_n     = (state == ST_STROBE);
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_n  = rep_cnt;
`endif

        case (state)
            ST_SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (exactly_one_low(row_p1)) begin
                        row_lat_n = row_p1;
                        cnt_n     = '0;
                        state_n   = ST_DEBOUNCE;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end else begin
                    scan_cnt_n = scan_cnt + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (row_p1 != row_lat) begin
                    state_n    = ST_SCAN;
                    col_idx_n  = col_idx + 2'd1;
                    scan_cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = ST_EMIT;
                end else begin
                    cnt_n = sat_inc_deb(cnt);
                end
            end

            ST_EMIT: begin
                value_n    = encode(row_index(row_lat), col_idx);
                key_down_n = 1'b1;
                stb_cnt_n  = '0;
                state_n    = ST_STROBE;
            end

            ST_STROBE: begin
                if (stb_cnt == STB_LAST) begin
                    state_n = ST_HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt_n = '0;
`endif
                end else begin
                    stb_cnt_n = stb_cnt + 1'b1;
                end
            end

            ST_HOLD: begin
                // Other keys are ignored: only an all-high row bus starts release
                if (row_p1 == 4'hF) begin
                    cnt_n   = '0;
                    state_n = ST_RELEASE;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rep_cnt == REP_LAST) begin
                    rep_cnt_n = '0;
                    stb_cnt_n = '0;
                    state_n   = ST_STROBE;
                end else begin
                    rep_cnt_n = sat_inc_rep(rep_cnt);
                end
`endif
            end

            ST_RELEASE: begin
                if (row_p1 != 4'hF) begin
                    state_n = ST_HOLD;
                end else if (cnt == DEB_FULL) begin
                    key_down_n = 1'b0;
                    col_idx_n  = col_idx + 2'd1;
                    scan_cnt_n = '0;
                    state_n    = ST_SCAN;
                end else begin
                    cnt_n = sat_inc_deb(cnt);
                end
            end

            default: begin
                state_n = ST_SCAN;
            end
        endcase
    end

    assign kp.col      = ~(4'b0001 << col_idx);
    assign kp.value    = value_q;
    assign kp.trig     = trig_q;
    assign kp.key_down = key_down_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a behavioural 4x4 matrix drives the rows
// from the scanned columns, and each step checks outputs with immediate assertions.
module tb_keypad_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int TRIG_LEN = 2;
    localparam int REP      = 100;

    logic        clk = 1'b0;
    logic        clr_all = 1'b0;
    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_if kif();

    keypad_encoder #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .TRIG_LEN        (TRIG_LEN),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk     (clk),
        .clr_all (clr_all),
        .kp      (kif)
    );

    // Matrix model: a held key pulls its row low while its column is driven low
    always_comb begin
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (keys[ri*4+ci] && !kif.col[ci]) r[ri] = 1'b0;
        kif.row = r;
    end

    int         n_pulse = 0;
    int         width = 0;
    int         last_width = 0;
    logic       trig_d = 1'b0;
    logic [3:0] val_d = 4'h0;
    logic [3:0] val_before = 4'h0;

    always @(negedge clk) begin
        if (kif.trig && !trig_d) begin
            n_pulse++;
            val_before = val_d;
            width = 1;
        end else if (kif.trig) begin
            width++;
        end
        if (kif.trig) last_width = width;
        trig_d = kif.trig;
        val_d  = kif.value;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         base;
        logic [3:0] exp_col;
        logic [3:0] seen;
        logic       kd_seen;
        logic       found;

        // Reset state
        cyc(3);
        check("rst_col", kif.col, 4'b1110);
        check("rst_value", kif.value, 4'h0);
        check("rst_trig", kif.trig, 1'b0);
        check("rst_key_down", kif.key_down, 1'b0);
        clr_all = 1'b1;

        // 1: idle scanning, 4 cycles per column
        for (int i = 0; i < 16; i++) begin
            cyc(4);
            exp_col = ~(4'b0001 << ((i + 1) % 4));
            check("t1_col", kif.col, exp_col);
            check("t1_trig", kif.trig, 1'b0);
        end
        check("t1_value", kif.value, 4'h0);
        check("t1_key_down", kif.key_down, 1'b0);
        check("t1_pulses", n_pulse, 0);

        // 2: clean press r1c3
        base = n_pulse;
        keys[7] = 1'b1;
        cyc(100);
        check("t2_col_a", kif.col, 4'b0111);
        check("t2_key_down", kif.key_down, 1'b1);
        cyc(100);
        check("t2_col_b", kif.col, 4'b0111);
        check("t2_pulses", n_pulse - base, 1);
        check("t2_width", last_width, TRIG_LEN);
        check("t2_val_lead", val_before, 4'b1011);
        check("t2_value", kif.value, 4'b1011);
        keys[7] = 1'b0;
        cyc(6);
        check("t2_kd_early", kif.key_down, 1'b1);
        cyc(24);
        check("t2_kd_late", kif.key_down, 1'b0);
        check("t2_value_kept", kif.value, 4'b1011);
        check("t2_pulses_rel", n_pulse - base, 1);

        // 3: bouncing press r0c1
        base = n_pulse;
        for (int b = 0; b < 7; b++) begin
            keys[1] = 1'b1;
            cyc(3);
            keys[1] = 1'b0;
            cyc(3);
        end
        check("t3_no_pulse", n_pulse - base, 0);
        check("t3_kd_bounce", kif.key_down, 1'b0);
        keys[1] = 1'b1;
        cyc(100);
        check("t3_pulses", n_pulse - base, 1);
        check("t3_val_lead", val_before, 4'b0010);
        check("t3_width", last_width, TRIG_LEN);
        check("t3_col", kif.col, 4'b1101);
        keys[1] = 1'b0;
        cyc(40);
        check("t3_kd_rel", kif.key_down, 1'b0);

        // 4: two keys in one column are not a key
        base = n_pulse;
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        seen = 4'h0;
        kd_seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            seen = seen | ~kif.col;
            kd_seen = kd_seen | kif.key_down;
        end
        check("t4_scan_all", seen, 4'hF);
        check("t4_no_kd", kd_seen, 1'b0);
        check("t4_no_pulse", n_pulse - base, 0);
        keys[4] = 1'b0;
        cyc(100);
        check("t4_pulses", n_pulse - base, 1);
        check("t4_val_lead", val_before, 4'b0001);
        check("t4_value", kif.value, 4'b0001);
        keys = '0;
        cyc(40);

        // 5: long hold r3c3
        base = n_pulse;
        keys[15] = 1'b1;
        cyc(1000);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("t5_repeats", (n_pulse - base) >= 2, 1'b1);
`else
        check("t5_pulses", n_pulse - base, 1);
`endif
        check("t5_val_lead", val_before, 4'b1111);
        check("t5_value", kif.value, 4'b1111);
        check("t5_width", last_width, TRIG_LEN);
        keys = '0;
        cyc(40);
        check("t5_kd_rel", kif.key_down, 1'b0);

        // 6: reset during first trig cycle of r2c2
        keys[10] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc(1);
            if (kif.trig) found = 1'b1;
        end
        check("t6_trig_seen", found, 1'b1);
        clr_all = 1'b0;
        #1;
        check("t6_rst_trig", kif.trig, 1'b0);
        check("t6_rst_kd", kif.key_down, 1'b0);
        check("t6_rst_value", kif.value, 4'h0);
        check("t6_rst_col", kif.col, 4'b1110);
        cyc(2);
        clr_all = 1'b1;
        base = n_pulse;
        cyc(200);
        check("t6_pulses", n_pulse - base, 1);
        check("t6_val_lead", val_before, 4'b1001);
        check("t6_value", kif.value, 4'b1001);
        check("t6_kd", kif.key_down, 1'b1);
        keys = '0;
        cyc(40);
        check("t6_kd_rel", kif.key_down, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
